// File: rtl/imem_dmem_port_arbiter.sv
// Shares the single core memory port between the instruction fetcher
// (I-side) and the load/store unit (D-side). Only one transaction is in
// flight at a time, and priority alternates between the two sides.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction; grant a requester (after a one-cycle rest)
// ISSUE    | mem_addr_valid_out held high until memory accepts
// WAIT_RSP | accepted; waiting for response data or the timeout
module imem_dmem_port_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_in,
    input  logic                  i_req_valid_in,
    output logic                  i_req_ack_out,
    output logic [DATA_WIDTH-1:0] i_rsp_data_out,
    output logic                  i_rsp_valid_out,
    input  logic [ADDR_WIDTH-1:0] d_req_addr_in,
    input  logic                  d_req_we_in,
    input  logic [DATA_WIDTH-1:0] d_req_wdata_in,
    input  logic                  d_req_valid_in,
    output logic                  d_req_ack_out,
    output logic [DATA_WIDTH-1:0] d_rsp_data_out,
    output logic                  d_rsp_valid_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                  mem_we_out,
    output logic [DATA_WIDTH-1:0] mem_wdata_out,
    output logic                  mem_addr_valid_out,
    input  logic                  mem_ack_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_data_valid_in,
    output logic                  timeout_err_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t                state_q;
    logic                  rest_q;      // forces one idle cycle after each transaction
    logic                  prio_d_q;    // 1: D-side wins a tie
    logic                  owner_d_q;   // 1: current transaction belongs to D-side
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  mem_addr_valid_q;
    logic                  i_req_ack_q;
    logic                  i_rsp_valid_q;
    logic [DATA_WIDTH-1:0] i_rsp_data_q;
    logic                  d_req_ack_q;
    logic                  d_rsp_valid_q;
    logic [DATA_WIDTH-1:0] d_rsp_data_q;
    logic                  timeout_err_q;

    logic                  pick_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] d_rsp_data_d;

    assign pick_d       = d_req_valid_in & (~i_req_valid_in | prio_d_q);
    assign cnt_inc      = cnt_q + 1'b1;
    // Stores complete with zero data rather than whatever memory returns.
    assign d_rsp_data_d = mem_we_q ? '0 : mem_data_in;

    // Request FSM with all outputs registered.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q          <= IDLE;
            rest_q           <= 1'b0;
            prio_d_q         <= 1'b0;
            owner_d_q        <= 1'b0;
            cnt_q            <= '0;
            mem_addr_q       <= '0;
            mem_we_q         <= 1'b0;
            mem_wdata_q      <= '0;
            mem_addr_valid_q <= 1'b0;
            i_req_ack_q      <= 1'b0;
            i_rsp_valid_q    <= 1'b0;
            i_rsp_data_q     <= '0;
            d_req_ack_q      <= 1'b0;
            d_rsp_valid_q    <= 1'b0;
            d_rsp_data_q     <= '0;
            timeout_err_q    <= 1'b0;
        end else begin
            i_req_ack_q   <= 1'b0;
            d_req_ack_q   <= 1'b0;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rest_q) begin
                        rest_q <= 1'b0;
                    end else if (i_req_valid_in || d_req_valid_in) begin
                        owner_d_q        <= pick_d;
                        mem_addr_q       <= pick_d ? d_req_addr_in : i_req_addr_in;
                        mem_we_q         <= pick_d & d_req_we_in;
                        mem_wdata_q      <= pick_d ? d_req_wdata_in : '0;
                        mem_addr_valid_q <= 1'b1;
                        state_q          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ack_in) begin
                        mem_addr_valid_q <= 1'b0;
                        cnt_q            <= '0;
                        i_req_ack_q      <= ~owner_d_q;
                        d_req_ack_q      <= owner_d_q;
                        if (mem_data_valid_in) begin
                            i_rsp_valid_q <= ~owner_d_q;
                            d_rsp_valid_q <= owner_d_q;
                            if (owner_d_q) d_rsp_data_q <= d_rsp_data_d;
                            else           i_rsp_data_q <= mem_data_in;
                            prio_d_q <= ~owner_d_q;
                            rest_q   <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (mem_data_valid_in) begin
                        i_rsp_valid_q <= ~owner_d_q;
                        d_rsp_valid_q <= owner_d_q;
                        if (owner_d_q) d_rsp_data_q <= d_rsp_data_d;
                        else           i_rsp_data_q <= mem_data_in;
                        prio_d_q <= ~owner_d_q;
                        rest_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                            timeout_err_q <= 1'b1;
                            prio_d_q      <= ~owner_d_q;
                            rest_q        <= 1'b1;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr_out       = mem_addr_q;
    assign mem_we_out         = mem_we_q;
    assign mem_wdata_out      = mem_wdata_q;
    assign mem_addr_valid_out = mem_addr_valid_q;
    assign i_req_ack_out      = i_req_ack_q;
    assign i_rsp_valid_out    = i_rsp_valid_q;
    assign i_rsp_data_out     = i_rsp_data_q;
    assign d_req_ack_out      = d_req_ack_q;
    assign d_rsp_valid_out    = d_rsp_valid_q;
    assign d_rsp_data_out     = d_rsp_data_q;
    assign timeout_err_out    = timeout_err_q;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: directed scenarios plus a randomized
// transaction loop checked against a transaction-level round-robin model.
module tb_imem_dmem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 128;
    localparam int TO = 8;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b1;
    logic [AW-1:0] i_req_addr_in = '0;
    logic          i_req_valid_in = 1'b0;
    logic          i_req_ack_out;
    logic [DW-1:0] i_rsp_data_out;
    logic          i_rsp_valid_out;
    logic [AW-1:0] d_req_addr_in = '0;
    logic          d_req_we_in = 1'b0;
    logic [DW-1:0] d_req_wdata_in = '0;
    logic          d_req_valid_in = 1'b0;
    logic          d_req_ack_out;
    logic [DW-1:0] d_rsp_data_out;
    logic          d_rsp_valid_out;
    logic [AW-1:0] mem_addr_out;
    logic          mem_we_out;
    logic [DW-1:0] mem_wdata_out;
    logic          mem_addr_valid_out;
    logic          mem_ack_in = 1'b0;
    logic [DW-1:0] mem_data_in = '0;
    logic          mem_data_valid_in = 1'b0;
    logic          timeout_err_out;

    int   total = 0;
    int   bad = 0;
    logic prio_m = 1'b0;   // model: 1 means D-side wins a tie

    imem_dmem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .i_req_addr_in(i_req_addr_in), .i_req_valid_in(i_req_valid_in),
        .i_req_ack_out(i_req_ack_out), .i_rsp_data_out(i_rsp_data_out),
        .i_rsp_valid_out(i_rsp_valid_out),
        .d_req_addr_in(d_req_addr_in), .d_req_we_in(d_req_we_in),
        .d_req_wdata_in(d_req_wdata_in), .d_req_valid_in(d_req_valid_in),
        .d_req_ack_out(d_req_ack_out), .d_rsp_data_out(d_rsp_data_out),
        .d_rsp_valid_out(d_rsp_valid_out),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
        .mem_wdata_out(mem_wdata_out), .mem_addr_valid_out(mem_addr_valid_out),
        .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in),
        .mem_data_valid_in(mem_data_valid_in), .timeout_err_out(timeout_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        tick();
        total++; if ({i_req_ack_out, i_rsp_valid_out, d_req_ack_out, d_rsp_valid_out, mem_we_out, mem_addr_valid_out, timeout_err_out} !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {i_req_ack_out, i_rsp_valid_out, d_req_ack_out, d_rsp_valid_out, mem_we_out, mem_addr_valid_out, timeout_err_out}); end
        total++; if ({mem_addr_out, mem_wdata_out, i_rsp_data_out, d_rsp_data_out} !== '0) begin bad++; $display("FAIL reset_buses got=%0h exp=0", {mem_addr_out, mem_wdata_out, i_rsp_data_out, d_rsp_data_out}); end
        reset_in = 1'b0;
        tick();
        total++; if (mem_addr_valid_out !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", mem_addr_valid_out); end
        prio_m = 1'b0;
    endtask

    task automatic test_i_fetch();
        logic [DW-1:0] rd;
        rd = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        i_req_addr_in = 64'h1000; i_req_valid_in = 1'b1;
        tick();
        total++; if ({mem_addr_valid_out, mem_we_out} !== 2'b10 || mem_addr_out !== 64'h1000) begin bad++; $display("FAIL ifetch_issue got=%b/%0h exp=10/1000", {mem_addr_valid_out, mem_we_out}, mem_addr_out); end
        tick();
        total++; if (mem_addr_valid_out !== 1'b1) begin bad++; $display("FAIL ifetch_hold got=%b exp=1", mem_addr_valid_out); end
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        total++; if ({i_req_ack_out, mem_addr_valid_out, d_req_ack_out} !== 3'b100) begin bad++; $display("FAIL ifetch_ack got=%b exp=100", {i_req_ack_out, mem_addr_valid_out, d_req_ack_out}); end
        i_req_valid_in = 1'b0;
        tick();
        total++; if (i_req_ack_out !== 1'b0) begin bad++; $display("FAIL ifetch_ack_pulse got=%b exp=0", i_req_ack_out); end
        mem_data_valid_in = 1'b1; mem_data_in = rd;
        tick();
        mem_data_valid_in = 1'b0;
        total++; if (i_rsp_valid_out !== 1'b1 || i_rsp_data_out !== rd) begin bad++; $display("FAIL ifetch_rsp got=%b/%0h exp=1/%0h", i_rsp_valid_out, i_rsp_data_out, rd); end
        total++; if ({d_req_ack_out, d_rsp_valid_out} !== 2'b00 || d_rsp_data_out !== '0) begin bad++; $display("FAIL ifetch_dside got=%b/%0h exp=00/0", {d_req_ack_out, d_rsp_valid_out}, d_rsp_data_out); end
        tick();
        total++; if (i_rsp_valid_out !== 1'b0) begin bad++; $display("FAIL ifetch_rsp_pulse got=%b exp=0", i_rsp_valid_out); end
        prio_m = 1'b1;
    endtask

    task automatic test_d_store();
        logic [DW-1:0] wd;
        wd = {4{32'h55555555}};
        d_req_addr_in = 64'h2000; d_req_we_in = 1'b1; d_req_wdata_in = wd; d_req_valid_in = 1'b1;
        tick();
        total++; if ({mem_addr_valid_out, mem_we_out} !== 2'b11 || mem_addr_out !== 64'h2000 || mem_wdata_out !== wd) begin bad++; $display("FAIL store_issue got=%b/%0h/%0h exp=11/2000/%0h", {mem_addr_valid_out, mem_we_out}, mem_addr_out, mem_wdata_out, wd); end
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        total++; if ({d_req_ack_out, i_req_ack_out, mem_addr_valid_out} !== 3'b100) begin bad++; $display("FAIL store_ack got=%b exp=100", {d_req_ack_out, i_req_ack_out, mem_addr_valid_out}); end
        d_req_valid_in = 1'b0; d_req_we_in = 1'b0;
        mem_data_valid_in = 1'b1; mem_data_in = {4{32'hAAAAAAAA}};
        tick();
        mem_data_valid_in = 1'b0;
        total++; if ({d_rsp_valid_out, i_rsp_valid_out} !== 2'b10 || d_rsp_data_out !== '0) begin bad++; $display("FAIL store_rsp got=%b/%0h exp=10/0", {d_rsp_valid_out, i_rsp_valid_out}, d_rsp_data_out); end
        tick();
        prio_m = 1'b0;
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] rd;
        rd = {$urandom, $urandom, $urandom, $urandom};
        i_req_addr_in = 64'h3000; i_req_valid_in = 1'b1;
        tick();
        total++; if (mem_addr_valid_out !== 1'b1 || mem_addr_out !== 64'h3000) begin bad++; $display("FAIL same_issue got=%b/%0h exp=1/3000", mem_addr_valid_out, mem_addr_out); end
        mem_ack_in = 1'b1; mem_data_valid_in = 1'b1; mem_data_in = rd;
        tick();
        mem_ack_in = 1'b0; mem_data_valid_in = 1'b0;
        total++; if ({i_req_ack_out, i_rsp_valid_out, mem_addr_valid_out} !== 3'b110 || i_rsp_data_out !== rd) begin bad++; $display("FAIL same_pulses got=%b/%0h exp=110/%0h", {i_req_ack_out, i_rsp_valid_out, mem_addr_valid_out}, i_rsp_data_out, rd); end
        i_req_valid_in = 1'b0;
        // A pending D request is only grantable if the FSM went back to IDLE.
        d_req_addr_in = 64'h3400; d_req_we_in = 1'b0; d_req_valid_in = 1'b1;
        tick();
        total++; if ({i_req_ack_out, i_rsp_valid_out, mem_addr_valid_out} !== 3'b000) begin bad++; $display("FAIL same_rest got=%b exp=000", {i_req_ack_out, i_rsp_valid_out, mem_addr_valid_out}); end
        tick();
        total++; if (mem_addr_valid_out !== 1'b1 || mem_addr_out !== 64'h3400) begin bad++; $display("FAIL same_next_grant got=%b/%0h exp=1/3400", mem_addr_valid_out, mem_addr_out); end
        mem_ack_in = 1'b1; mem_data_valid_in = 1'b1; mem_data_in = ~rd;
        tick();
        mem_ack_in = 1'b0; mem_data_valid_in = 1'b0;
        total++; if ({d_req_ack_out, d_rsp_valid_out} !== 2'b11 || d_rsp_data_out !== ~rd) begin bad++; $display("FAIL same_dload got=%b/%0h exp=11/%0h", {d_req_ack_out, d_rsp_valid_out}, d_rsp_data_out, ~rd); end
        d_req_valid_in = 1'b0;
        tick();
        prio_m = 1'b0;
    endtask

    task automatic test_back_to_back();
        int            rise[4];
        int            cyc;
        int            n;
        logic          own_d;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] rd;
        cyc = 0;
        i_req_addr_in = 64'h4000; d_req_addr_in = 64'h5000; d_req_we_in = 1'b0;
        i_req_valid_in = 1'b1; d_req_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            own_d = prio_m;
            exp_a = own_d ? d_req_addr_in : i_req_addr_in;
            n = 0;
            tick(); cyc++;
            while (mem_addr_valid_out !== 1'b1 && n < 10) begin tick(); cyc++; n++; end
            rise[k] = cyc;
            total++; if (mem_addr_valid_out !== 1'b1 || mem_addr_out !== exp_a) begin bad++; $display("FAIL b2b_grant%0d got=%b/%0h exp=1/%0h", k, mem_addr_valid_out, mem_addr_out, exp_a); end
            if (k > 0) begin
                total++; if (rise[k] - rise[k-1] !== 4) begin bad++; $display("FAIL b2b_spacing%0d got=%0d exp=4", k, rise[k] - rise[k-1]); end
            end
            mem_ack_in = 1'b1;
            tick(); cyc++;
            mem_ack_in = 1'b0;
            total++; if ({i_req_ack_out, d_req_ack_out} !== {~own_d, own_d}) begin bad++; $display("FAIL b2b_ack%0d got=%b exp=%b", k, {i_req_ack_out, d_req_ack_out}, {~own_d, own_d}); end
            if (own_d) d_req_addr_in = d_req_addr_in + 64'h10;
            else       i_req_addr_in = i_req_addr_in + 64'h10;
            rd = {$urandom, $urandom, $urandom, $urandom};
            mem_data_valid_in = 1'b1; mem_data_in = rd;
            tick(); cyc++;
            mem_data_valid_in = 1'b0;
            total++; if ({i_rsp_valid_out, d_rsp_valid_out} !== {~own_d, own_d} || (own_d ? d_rsp_data_out : i_rsp_data_out) !== rd) begin bad++; $display("FAIL b2b_rsp%0d got=%b exp=%b", k, {i_rsp_valid_out, d_rsp_valid_out}, {~own_d, own_d}); end
            prio_m = ~own_d;
        end
        i_req_valid_in = 1'b0; d_req_valid_in = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int            sel, a, b;
        logic          own_d, we, same;
        logic [AW-1:0] ia, da, exp_a;
        logic [DW-1:0] wd, rd, exp_rd;
        for (int it = 0; it < 24; it++) begin
            sel = int'($urandom_range(1, 3));
            ia = {$urandom, $urandom}; da = {$urandom, $urandom};
            wd = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            we = 1'($urandom_range(0, 1));
            own_d = (sel == 3) ? prio_m : (sel == 2);
            exp_a = own_d ? da : ia;
            exp_rd = (own_d && we) ? '0 : rd;
            i_req_addr_in = ia; i_req_valid_in = sel[0];
            d_req_addr_in = da; d_req_we_in = we; d_req_wdata_in = wd; d_req_valid_in = sel[1];
            tick();
            total++; if (mem_addr_valid_out !== 1'b1 || mem_addr_out !== exp_a || mem_we_out !== (own_d & we) || mem_wdata_out !== (own_d ? wd : '0)) begin bad++; $display("FAIL rnd_issue%0d got=%b/%0h/%b exp=1/%0h/%b", it, mem_addr_valid_out, mem_addr_out, mem_we_out, exp_a, own_d & we); end
            a = int'($urandom_range(0, 2));
            repeat (a) begin
                mem_data_valid_in = 1'($urandom_range(0, 1)); mem_data_in = ~rd;
                tick();
                total++; if ({mem_addr_valid_out, i_rsp_valid_out, d_rsp_valid_out, i_req_ack_out, d_req_ack_out} !== 5'b10000) begin bad++; $display("FAIL rnd_wait_ack%0d got=%b exp=10000", it, {mem_addr_valid_out, i_rsp_valid_out, d_rsp_valid_out, i_req_ack_out, d_req_ack_out}); end
            end
            same = ($urandom_range(0, 3) == 0);
            mem_ack_in = 1'b1; mem_data_valid_in = same; mem_data_in = rd;
            tick();
            mem_ack_in = 1'b0; mem_data_valid_in = 1'b0;
            total++; if ({i_req_ack_out, d_req_ack_out, mem_addr_valid_out} !== {~own_d, own_d, 1'b0}) begin bad++; $display("FAIL rnd_ack%0d got=%b exp=%b", it, {i_req_ack_out, d_req_ack_out, mem_addr_valid_out}, {~own_d, own_d, 1'b0}); end
            if (own_d) d_req_valid_in = 1'b0; else i_req_valid_in = 1'b0;
            if (!same) begin
                total++; if ({i_rsp_valid_out, d_rsp_valid_out} !== 2'b00) begin bad++; $display("FAIL rnd_early_rsp%0d got=%b exp=00", it, {i_rsp_valid_out, d_rsp_valid_out}); end
                b = int'($urandom_range(0, 3));
                repeat (b) tick();
                mem_data_valid_in = 1'b1; mem_data_in = rd;
                tick();
                mem_data_valid_in = 1'b0;
            end
            total++; if ({i_rsp_valid_out, d_rsp_valid_out} !== {~own_d, own_d} || (own_d ? d_rsp_data_out : i_rsp_data_out) !== exp_rd) begin bad++; $display("FAIL rnd_rsp%0d got=%b/%0h exp=%b/%0h", it, {i_rsp_valid_out, d_rsp_valid_out}, own_d ? d_rsp_data_out : i_rsp_data_out, {~own_d, own_d}, exp_rd); end
            prio_m = ~own_d;
            i_req_valid_in = 1'b0; d_req_valid_in = 1'b0;
            tick();
        end
    endtask

    task automatic test_timeout();
        int n;
        i_req_addr_in = 64'h6000; i_req_valid_in = 1'b1;
        tick();
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        i_req_valid_in = 1'b0;
        d_req_addr_in = 64'hD00D; d_req_we_in = 1'b0; d_req_valid_in = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            tick();
            total++; if (timeout_err_out !== (k >= TO) || {i_rsp_valid_out, d_rsp_valid_out, mem_addr_valid_out} !== 3'b000) begin bad++; $display("FAIL to_cycle%0d got=%b/%b exp=%b/000", k, timeout_err_out, {i_rsp_valid_out, d_rsp_valid_out, mem_addr_valid_out}, k >= TO); end
        end
        prio_m = 1'b1;
        n = 0;
        while (mem_addr_valid_out !== 1'b1 && n < 10) begin tick(); n++; end
        total++; if (mem_addr_valid_out !== 1'b1 || mem_addr_out !== 64'hD00D || n !== 2) begin bad++; $display("FAIL to_next_grant got=%b/%0h/%0d exp=1/d00d/2", mem_addr_valid_out, mem_addr_out, n); end
        mem_ack_in = 1'b1; mem_data_valid_in = 1'b1; mem_data_in = 128'h1234;
        tick();
        mem_ack_in = 1'b0; mem_data_valid_in = 1'b0;
        total++; if ({d_req_ack_out, d_rsp_valid_out, timeout_err_out} !== 3'b111 || d_rsp_data_out !== 128'h1234) begin bad++; $display("FAIL to_recover got=%b/%0h exp=111/1234", {d_req_ack_out, d_rsp_valid_out, timeout_err_out}, d_rsp_data_out); end
        d_req_valid_in = 1'b0;
        prio_m = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_req_addr_in = 64'h7000; d_req_we_in = 1'b0; d_req_valid_in = 1'b1;
        tick();
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        d_req_valid_in = 1'b0;
        total++; if (d_req_ack_out !== 1'b1) begin bad++; $display("FAIL rst_mid_ack got=%b exp=1", d_req_ack_out); end
        #2 reset_in = 1'b1;
        #1;
        total++; if ({i_req_ack_out, i_rsp_valid_out, d_req_ack_out, d_rsp_valid_out, mem_we_out, mem_addr_valid_out, timeout_err_out} !== 7'b0 || mem_addr_out !== '0 || d_rsp_data_out !== '0) begin bad++; $display("FAIL rst_mid_clear got=%b/%0h exp=0/0", {i_req_ack_out, i_rsp_valid_out, d_req_ack_out, d_rsp_valid_out, mem_we_out, mem_addr_valid_out, timeout_err_out}, mem_addr_out); end
        tick();
        reset_in = 1'b0;
        prio_m = 1'b0;
        mem_data_valid_in = 1'b1; mem_data_in = 128'hBAD;
        tick();
        mem_data_valid_in = 1'b0;
        total++; if ({i_rsp_valid_out, d_rsp_valid_out, mem_addr_valid_out} !== 3'b000) begin bad++; $display("FAIL rst_mid_late got=%b exp=000", {i_rsp_valid_out, d_rsp_valid_out, mem_addr_valid_out}); end
        tick();
        total++; if ({i_rsp_valid_out, d_rsp_valid_out, d_rsp_data_out != '0} !== 3'b000) begin bad++; $display("FAIL rst_mid_quiet got=%b exp=000", {i_rsp_valid_out, d_rsp_valid_out, d_rsp_data_out != '0}); end
    endtask

    initial begin
        test_reset();
        test_i_fetch();
        test_d_store();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares the single core memory port between the instruction fetcher (I-side) and the load/store unit (D-side).
- Uses a 3-state request FSM with round-robin priority and a one-outstanding-transaction rule.
- Routes read data back to the owning requester.
- Detects hung transactions with a response timeout counter.

Parameters:
ADDR_WIDTH, 64, request address width (CPU word length)
DATA_WIDTH, 128, memory data bus width (instruction fetch width)
TIMEOUT_CYCLES, 255, max cycles in WAIT_RSP before abort; counter width = clog2(TIMEOUT_CYCLES+1)

Ports:
clk_in  input  1  clock
reset_in  input  1  asynchronous active-high reset
i_req_addr_in  input  ADDR_WIDTH  fetch address
i_req_valid_in  input  1  fetch request; held with addr stable until i_req_ack_out
i_req_ack_out  output  1  one-cycle pulse: fetch request accepted by memory
i_rsp_data_out  output  DATA_WIDTH  fetch data
i_rsp_valid_out  output  1  one-cycle pulse: i_rsp_data_out valid
d_req_addr_in  input  ADDR_WIDTH  load/store address
d_req_we_in  input  1  1 = store
d_req_wdata_in  input  DATA_WIDTH  store data
d_req_valid_in  input  1  data request; held stable until d_req_ack_out
d_req_ack_out  output  1  one-cycle pulse: data request accepted
d_rsp_data_out  output  DATA_WIDTH  load data (zero for stores)
d_rsp_valid_out  output  1  one-cycle pulse: load data / store completion
mem_addr_out  output  ADDR_WIDTH  memory address
mem_we_out  output  1  memory write enable
mem_wdata_out  output  DATA_WIDTH  memory write data
mem_addr_valid_out  output  1  memory request valid
mem_ack_in  input  1  memory accepted request
mem_data_in  input  DATA_WIDTH  memory response data
mem_data_valid_in  input  1  memory response valid
timeout_err_out  output  1  sticky: a transaction was aborted by timeout

Behaviour:
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE; priority pointer resets to I-side; timeout counter resets to 0.
- IDLE:
  - If no requester is valid, stay in IDLE.
  - If only one requester is valid, grant it.
  - If both are valid, grant the side named by the priority pointer.
  - On grant: latch addr/we/wdata and the owner into mem_*_out; mem_addr_valid_out=1 next cycle; go to ISSUE. Request-to-mem_addr_valid_out latency is 1 cycle.
  - An I-side grant forces mem_we_out=0 and mem_wdata_out=0.
- ISSUE:
  - mem_addr_valid_out is held 1 and mem_* are held stable until mem_ack_in.
  - On mem_ack_in: next cycle mem_addr_valid_out=0, the owner's req_ack pulses for 1 cycle, go to WAIT_RSP, and the timeout counter is cleared.
- WAIT_RSP:
  - On mem_data_valid_in: next cycle the owner's rsp_valid pulses for 1 cycle, with rsp_data = mem_data_in (D-side stores return 0). Priority pointer flips to the non-owner side. Go to IDLE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES, set timeout_err_out, go to IDLE, flip priority, and emit no rsp_valid. timeout_err_out clears only on reset.
- mem_ack_in and mem_data_valid_in in the same ISSUE cycle: treated as both events. The owner gets req_ack and rsp_valid in the same next cycle, and the FSM goes directly to IDLE.
- mem_data_valid_in in IDLE or ISSUE without a same-cycle ack: ignored, no response routed.
- mem_ack_in outside ISSUE: ignored.
- One transaction outstanding at a time; a new grant cannot occur before the cycle after returning to IDLE. Back-to-back throughput is therefore at most one transaction per 4 cycles with 1-cycle memory.
- Requester deasserts valid during ISSUE: illegal. The latched request still completes and its ack/rsp are still pulsed.
- Reset asserted mid-transaction: immediate abort, all outputs to 0, no response delivered; requesters must re-issue.
- Non-owner request inputs are never sampled while FSM is not in IDLE.

Test Plan:
- I-only fetch: i_req addr 0x1000 at cycle 0, mem_ack at cycle 2, mem_data 0xDEADBEEF.. at cycle 4 -> mem_addr_valid_out=1 cycles 1-2, i_req_ack_out at cycle 3, i_rsp_valid_out at cycle 5 with data, d_* outputs stay 0.
- Both requesters held valid continuously for 4 transactions -> grant order I, D, I, D; mem_addr_out alternates between i/d addresses.
- D-side store: we=1, wdata=0x55..55, addr 0x2000 -> mem_we_out=1, mem_wdata_out=0x55..55 during ISSUE; d_rsp_valid_out pulses with d_rsp_data_out=0.
- Same-cycle ack and data in ISSUE -> req_ack and rsp_valid pulse together next cycle; FSM in IDLE the cycle after.
- Memory never responds (TIMEOUT_CYCLES=8) -> timeout_err_out rises 8 cycles after WAIT_RSP entry; no rsp_valid; next pending request is granted and completes normally; error stays 1.
- reset_in pulsed while in WAIT_RSP -> all outputs 0 immediately; a late mem_data_valid_in after reset is ignored.
